// File: rtl/act_pkg.sv
// Shared definitions for the activation window path: default sizes, mode
// codes, row-rotation encodings and the window-buffer state encoding.
package act_pkg;

  localparam int ACT_DATA_W = 16;
  localparam int ACT_IMG_W  = 16;

  localparam logic [1:0] MODE_CONV = 2'b01;
  localparam logic [1:0] MODE_FC   = 2'b10;

  // Row rotation: which memory feeds top/mid/bot (3 aliases rotation 0)
  localparam logic [1:0] ROW_SEL_123 = 2'd0;
  localparam logic [1:0] ROW_SEL_231 = 2'd1;
  localparam logic [1:0] ROW_SEL_312 = 2'd2;
  localparam logic [1:0] ROW_SEL_ALT = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FILL   = 2'b01,
    STREAM = 2'b10,
    FLUSH  = 2'b11
  } awb_state_e;

endpackage

// File: rtl/act_row_mux.sv
// Rotates the three activation-memory read ports into a top/mid/bot column
// and zeroes the top or bottom row at the image's first/last row.
module act_row_mux
  import act_pkg::*;
#(
  parameter int DATA_W = ACT_DATA_W
) (
  input  logic [DATA_W-1:0]   mem_1,
  input  logic [DATA_W-1:0]   mem_2,
  input  logic [DATA_W-1:0]   mem_3,
  input  logic [1:0]          row_sel,
  input  logic                pad_top,
  input  logic                pad_bot,
  output logic [3*DATA_W-1:0] col
);

  logic [DATA_W-1:0] top, mid, bot;

  always_comb begin
    top = mem_1;
    mid = mem_2;
    bot = mem_3;
    case (row_sel)
      ROW_SEL_231: begin
        top = mem_2;
        mid = mem_3;
        bot = mem_1;
      end
      ROW_SEL_312: begin
        top = mem_3;
        mid = mem_1;
        bot = mem_2;
      end
      default: ;
    endcase
    if (pad_top) top = '0;
    if (pad_bot) bot = '0;
    col = {bot, mid, top};
  end

endmodule

// File: rtl/act_window_buffer.sv
// 3x3 sliding-window builder between the activation memory controller and the
// conv PE array; one window per output column, zero-padded at left/right edges.
module act_window_buffer
  import act_pkg::*;
#(
  parameter int DATA_W    = ACT_DATA_W,
  parameter int IMG_W     = ACT_IMG_W,
  parameter int COL_CNT_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          row_sel,
  input  logic                pad_top,
  input  logic                pad_bot,
  input  logic                act_en,
  input  logic [DATA_W-1:0]   act_data_1,
  input  logic [DATA_W-1:0]   act_data_2,
  input  logic [DATA_W-1:0]   act_data_3,
  output logic [9*DATA_W-1:0] win_out,
  output logic                win_valid,
  output logic                row_done,
  output logic                busy,
  output logic                overrun_err
);

  localparam logic [COL_CNT_W-1:0] LAST_COL  = COL_CNT_W'(IMG_W - 1);
  localparam logic [COL_CNT_W-1:0] FULL_CNT  = COL_CNT_W'(IMG_W);
  localparam logic [COL_CNT_W:0]   REQ_LIMIT = (COL_CNT_W+1)'(IMG_W);

  awb_state_e           state_q, state_d;
  logic                 dvalid_p1;
  logic                 accept;
  logic                 err_set;
  logic [COL_CNT_W-1:0] col_cnt;
  logic [COL_CNT_W:0]   req_cnt;
  logic [1:0]           row_sel_q;
  logic                 pad_top_q, pad_bot_q;
  logic [3*DATA_W-1:0]  col_new, col_l, col_m, col_r;

  function automatic logic [9*DATA_W-1:0] pack_window(
    input logic [3*DATA_W-1:0] l,
    input logic [3*DATA_W-1:0] m,
    input logic [3*DATA_W-1:0] r
  );
    logic [9*DATA_W-1:0] w;
    for (int row = 0; row < 3; row++) begin
      w[(row*3)*DATA_W   +: DATA_W] = l[row*DATA_W +: DATA_W];
      w[(row*3+1)*DATA_W +: DATA_W] = m[row*DATA_W +: DATA_W];
      w[(row*3+2)*DATA_W +: DATA_W] = r[row*DATA_W +: DATA_W];
    end
    return w;
  endfunction

  act_row_mux #(.DATA_W(DATA_W)) u_row_mux (
    .mem_1   (act_data_1),
    .mem_2   (act_data_2),
    .mem_3   (act_data_3),
    .row_sel (row_sel_q),
    .pad_top (pad_top_q),
    .pad_bot (pad_bot_q),
    .col     (col_new)
  );

  // Columns requested so far: captured ones plus the one still in flight.
  assign req_cnt = {1'b0, col_cnt} + {{COL_CNT_W{1'b0}}, dvalid_p1};
  assign busy    = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          accept  = act_en;
        end
      end
      FILL: begin
        accept = act_en;
        if (dvalid_p1) state_d = STREAM;
      end
      STREAM: begin
        accept = act_en && (req_cnt < REQ_LIMIT);
        if (dvalid_p1 && (col_cnt == LAST_COL)) state_d = FLUSH;
      end
      FLUSH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    err_set = (start && (state_q != IDLE)) ||
              (act_en && !accept) ||
              (dvalid_p1 && (state_q == IDLE));
  end

  // Stage p1: read data arrives one cycle after the accepted strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dvalid_p1   <= 1'b0;
      col_cnt     <= '0;
      row_sel_q   <= '0;
      pad_top_q   <= 1'b0;
      pad_bot_q   <= 1'b0;
      col_l       <= '0;
      col_m       <= '0;
      col_r       <= '0;
      win_out     <= '0;
      win_valid   <= 1'b0;
      row_done    <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvalid_p1   <= accept;
      overrun_err <= overrun_err | err_set;
      win_valid   <= 1'b0;
      row_done    <= 1'b0;

      if ((state_q == IDLE) && start) begin
        row_sel_q <= row_sel;
        pad_top_q <= pad_top;
        pad_bot_q <= pad_bot;
        col_cnt   <= '0;
      end

      // Stage p2: column shift and window register
      if (dvalid_p1 && (state_q == FILL)) begin
        col_l   <= '0;
        col_m   <= '0;
        col_r   <= col_new;
        col_cnt <= COL_CNT_W'(1);
      end else if (dvalid_p1 && (state_q == STREAM)) begin
        col_l     <= col_m;
        col_m     <= col_r;
        col_r     <= col_new;
        win_out   <= pack_window(col_m, col_r, col_new);
        win_valid <= 1'b1;
        if (col_cnt != FULL_CNT) col_cnt <= col_cnt + COL_CNT_W'(1);
      end

      if (state_q == FLUSH) begin
        win_out   <= pack_window(col_m, col_r, '0);
        win_valid <= 1'b1;
        row_done  <= 1'b1;
      end
    end
  end

endmodule

// File: doc/act_window_buffer.md
Name: act_window_buffer

Overview:
- Sits directly downstream of the activation memory controller and upstream of the conv PE array.
- Takes the three activation-memory read ports and rotates them into top/mid/bottom rows according to the current output row.
- Builds a 3x3 sliding window with zero padding at the left/right image edges.
- Emits one window per output column, plus a row-done pulse at the end of each row pass.

Parameters:
- DATA_W, 16, width of one activation value.
- IMG_W, 16, columns per row pass (window count per pass); must be ≥ 2.
- COL_CNT_W, 5, column counter width; must satisfy 2^COL_CNT_W > IMG_W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse that begins a row pass; latches row_sel, pad_top, pad_bot.
- row_sel  in  2  row rotation: 0 = mem1/mem2/mem3 as top/mid/bot; 1 = mem2/mem3/mem1; 2 = mem3/mem1/mem2; 3 is treated as 0.
- pad_top  in  1  force the top row to zero for this pass (first image row).
- pad_bot  in  1  force the bottom row to zero for this pass (last image row).
- act_en  in  1  read strobe from the controller; the read data is valid in the following cycle.
- act_data_1  in  DATA_W  activation memory 1 read data.
- act_data_2  in  DATA_W  activation memory 2 read data.
- act_data_3  in  DATA_W  activation memory 3 read data.
- win_out  out  9*DATA_W  window; element i = r*3+c (r = 0 top, c = 0 left) at bits [i*DATA_W +: DATA_W].
- win_valid  out  1  win_out holds a new window this cycle.
- row_done  out  1  one-cycle pulse marking the final window of the pass.
- busy  out  1  high in any state other than IDLE.
- overrun_err  out  1  sticky error flag.

Behaviour:
- Reset: synchronous, while rst_n = 0 at a clock edge.
  - All outputs go to 0; state goes to IDLE.
  - Column registers, column counter, latched config and the data-valid pipe bit are all cleared.
  - A reset mid-pass aborts the pass; no row_done is generated.
- States and transitions:
  - IDLE → FILL on start.
  - FILL → STREAM after column 0 is captured.
  - STREAM → FLUSH after column IMG_W-1 is captured.
  - FLUSH → IDLE after one cycle.
- Data pipe:
  - dvalid is act_en delayed by one cycle.
  - On dvalid, the new column is formed: {top, mid, bot} after the row_sel mux, with pad_top/pad_bot zeroing applied.
  - Column registers shift: L <= M, M <= R, R <= new column.
  - The column counter increments on each captured column.
- Window emission:
  - Each column k ≥ 1, when captured, produces the window for column k-1, registered out in the next cycle.
  - That window is: left = column k-2 (zero when k-1 = 0), centre = column k-1, right = column k.
  - In FLUSH, the window for column IMG_W-1 is emitted with the right column zero; row_done is asserted in the same cycle.
  - Latency: act_en of column k at cycle t → its window (right = k) appears at t+2 with win_valid = 1.
  - Exactly IMG_W windows are produced per pass.
- Gaps in act_en are allowed:
  - win_valid is asserted only for new columns.
  - win_out holds its value while win_valid = 0.
- No back-pressure; the consumer must accept a window every cycle win_valid = 1.
- Boundary and error cases:
  - start while busy: ignored, and overrun_err is set.
  - act_en (or dvalid) in IDLE, or act_en in STREAM after IMG_W columns have been requested: the data is dropped and overrun_err is set.
  - start and the first act_en in the same cycle: legal; the act_en is accepted as column 0.
  - Column counter saturates at IMG_W and never wraps.
  - overrun_err is cleared only by reset.
- No arithmetic on data: pure selection and zeroing; all data widths are preserved.

Decomposition:
- Shared package act_pkg:
  - DATA_W and IMG_W defaults.
  - CONV/FC mode codes (2'b01 / 2'b10).
  - ROW_SEL_* encodings.
  - State encoding: IDLE = 2'b00, FILL = 2'b01, STREAM = 2'b10, FLUSH = 2'b11.
- One sub-module, act_row_mux: purely combinational.
  - Implements the row_sel rotation plus pad_top/pad_bot zeroing.
  - Reused by the FC path later.

Test Plan:
- Reset, then start with row_sel = 0 and no pads; 16 back-to-back act_en from cycle 0 with act_data_n = n*256 + col → win_valid in cycles 3..18.
  - First window: left = 0, centre col0, right col1.
  - row_done only in cycle 18, where right = 0.
  - 16 windows total.
- row_sel = 1 and row_sel = 2, otherwise the same as scenario 1 → top/mid/bot come from mem2/mem3/mem1 and mem3/mem1/mem2 respectively; row_sel = 3 matches row_sel = 0.
- pad_top = 1 on one pass and pad_bot = 1 on another → win_out elements 0..2 (respectively 6..8) are zero in every window; the other elements are unchanged.
- act_en pattern 1,0,0,1,1,0,... → windows appear exactly 2 cycles after each act_en from column 1 onward; win_out holds its value during gaps; still 16 windows and one row_done.
- Error cases → overrun_err goes to 1 and stays high through a later normal pass.
  - start mid-pass (at the 5th window): the pass continues unaffected.
  - A 17th act_en after the final column request: dropped.
- rst_n = 0 for one edge during the 8th window → next cycle all outputs and busy are 0; no row_done; a following start runs a clean pass.
